bitonic_stream_sorter: RTL and testbench
========================================

# bitonic_stream_sorter

Fully pipelined, parametrised bitonic sorting network that sorts one vector of `SIZE = 2**DEPTH` keys per cycle. It generalises the fixed 16-input, clock-only sorter with:
- a register after every compare stage;
- a valid/ready stream handshake with backpressure;
- a per-vector runtime sort direction;
- optional signed keys;
- a payload tag carried with each key.

It sits between a vector producer (e.g. a gather/DMA unit) and downstream top-k or merge logic.

## Interface
Parameters:
- `KEY_BITS`, default 8, width of each sort key.
- `TAG_BITS`, default 4, width of the payload that travels with each key; it is not compared.
- `DEPTH`, default 4, log2 of the vector size; legal range 1..6.
- `SIGNED`, default 0: 0 compares keys as unsigned, 1 compares them as two's complement.
- `SIZE`, default `1 << DEPTH`, derived; do not override.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  input vector present.
- `in_ready`  out  1  core accepts the input vector this cycle.
- `in_dir`  in  1  0 sorts ascending, 1 sorts descending; sampled with the vector.
- `in_keys`  in  `SIZE*KEY_BITS`  packed `[SIZE-1:0][KEY_BITS-1:0]`.
- `in_tags`  in  `SIZE*TAG_BITS`  packed `[SIZE-1:0][TAG_BITS-1:0]`; `in_tags[i]` belongs to `in_keys[i]`.
- `out_valid`  out  1  sorted vector present.
- `out_ready`  in  1  downstream accepts the output vector.
- `out_dir`  out  1  direction the output vector was sorted with.
- `out_keys`  out  `SIZE*KEY_BITS`  sorted keys; index 0 holds the smallest key when ascending, the largest when descending.
- `out_tags`  out  `SIZE*TAG_BITS`  tags permuted together with their keys.

## Operation
- Network: `S = DEPTH*(DEPTH+1)/2` compare stages, ordered by k = 1..DEPTH, then j = k-1 down to 0.
- In stage (k, j), element i with bit j = 0 pairs with element `i ^ (1<<j)`.
- That pair is ascending when bit k of i is 0 and descending otherwise. At k = DEPTH every pair is ascending.
- Runtime direction: the vector's dir bit XORs the swap decision of every comparator. dir = 1 therefore yields a full descending sort; no output reversal stage is used.
- Swap rule: swap only when lower-index key > upper-index key (strictly; after any XOR with dir). Equal keys never swap. The sort is not stable.
- Comparison uses `$signed` when `SIGNED` = 1 and is unsigned otherwise.
- Each tag moves with its key in every swap. The dir bit and a valid bit travel down the pipe with their vector.
- Pipeline: S register stages, each holding valid, dir, keys and tags. Stage 0 is fed from the inputs; stage S-1 drives the outputs.
- Flow control: `adv = !out_valid || out_ready`. The whole pipe shifts when `adv` is 1 and holds all stage contents when it is 0.
- `in_ready = adv && rst_n`.
- Input transfer occurs when `in_valid && in_ready`. If `adv` = 1 with `in_valid` = 0, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. The output is a registered copy of stage S-1.

## Timing
- Reset (`rst_n` low at a rising edge) clears every stage valid, `out_valid`, `out_dir`, `out_keys` and `out_tags` to 0.
- `in_ready` is 0 combinationally while `rst_n` is low.
- Reset mid-operation discards all in-flight vectors; no partial vector is ever output.
- Latency: a vector accepted at edge t appears with `out_valid` = 1 after edge t+S-1, given no stalls. This is 10 cycles for DEPTH = 4 and 6 cycles for DEPTH = 3.
- Throughput: one vector per cycle while `out_ready` stays 1.
- A stall of n cycles adds exactly n cycles to the latency of every in-flight vector.
- While `out_valid && !out_ready`, all `out_*` signals are held stable, `in_ready` is 0, and nothing is lost or duplicated.
- Simultaneous `out_ready` and `in_valid` with a full pipe: output transfer and input transfer occur on the same edge.

## Structure
- `sort_pkg` holds:
  - `function automatic int sort_stages(int depth)`, which returns S;
  - stage-to-(k, j) decode functions, used by the generate loops.
- Sub-module `sort_cas`: a combinational compare-exchange taking key/tag pairs, dir, a static ascending flag and `SIGNED`. The core instantiates it `SIZE/2` times per stage through generate loops.
- Core: S-deep register array, `adv` logic, and the valid/dir shift chain. Target size is roughly 200 RTL lines.

## Test plan
- **Basic ascending:** DEPTH=3, in_keys = {7,3,5,1,6,0,2,4} (index 0 first), in_tags = index, dir=0, out_ready=1 → 6 cycles later out_keys = {0,1,2,3,4,5,6,7} and out_tags = {5,3,6,1,7,2,4,0}.
- **Descending and signed:** same vector, dir=1 → out_keys = {7,...,0}. Separately, with SIGNED=1 and keys {-1,127,-128,0,...} ascending, -128 lands at index 0 and 127 at index 7.
- **Backpressure:** stream 20 random vectors with out_ready toggling randomly, checked against a reference-model scoreboard → every vector is emitted once, in order, with outputs stable during stalls.
- **Duplicates:** all keys 8'hAA with distinct tags → out_keys are all AA and the tags form a permutation of the inputs.
- **Reset mid-flight:** fill the pipe, pull rst_n low for 1 cycle → out_valid=0 and all outputs 0 the next cycle, no stale vector emerges, and the first new vector arrives after 6 cycles.
- **Full-rate random:** DEPTH=4, 1000 back-to-back vectors with random dir → output is sorted per out_dir, and the multiset of key/tag pairs is preserved.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorter: stage count and stage -> (k, j) decode.
// Stages run k = 1..DEPTH, and inside each k, j = k-1 down to 0.
package sort_pkg;

    localparam int MAX_DEPTH = 6;

    function automatic int sort_stages(int depth);
        return depth * (depth + 1) / 2;
    endfunction

    // Block-size exponent k of a stage; k-block n starts at stage sort_stages(n-1).
    function automatic int stage_k(int stage);
        int k;
        int base;
        k    = 1;
        base = 0;
        for (int kk = 1; kk <= MAX_DEPTH; kk++) begin
            if (stage >= base + kk) begin
                base = base + kk;
                k    = kk + 1;
            end
        end
        return k;
    endfunction

    // Partner distance exponent j of a stage, counting down inside its k block.
    function automatic int stage_j(int stage);
        int k;
        k = stage_k(stage);
        return k - 1 - (stage - sort_stages(k - 1));
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-exchange for one key/tag pair; zero latency, no flow control.
// Direction is the static network direction flipped by the vector's runtime dir bit.
module sort_cas #(
    parameter int KEY_BITS = 8,
    parameter int TAG_BITS = 4,
    parameter int SIGNED   = 0,
    parameter bit ASCEND   = 1'b1
) (
    input  logic                dir,
    input  logic [KEY_BITS-1:0] lo_key,
    input  logic [KEY_BITS-1:0] hi_key,
    input  logic [TAG_BITS-1:0] lo_tag,
    input  logic [TAG_BITS-1:0] hi_tag,
    output logic [KEY_BITS-1:0] res_lo_key,
    output logic [KEY_BITS-1:0] res_hi_key,
    output logic [TAG_BITS-1:0] res_lo_tag,
    output logic [TAG_BITS-1:0] res_hi_tag
);

    logic gt;
    logic lt;
    logic descend;
    logic swap;

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(lo_key) > $signed(hi_key);
            assign lt = $signed(lo_key) < $signed(hi_key);
        end else begin : g_unsigned
            assign gt = lo_key > hi_key;
            assign lt = lo_key < hi_key;
        end
    endgenerate

    // Strict compares in both directions so equal keys never move.
    assign descend = ASCEND ? dir : !dir;
    assign swap    = descend ? lt : gt;

    assign res_lo_key = swap ? hi_key : lo_key;
    assign res_hi_key = swap ? lo_key : hi_key;
    assign res_lo_tag = swap ? hi_tag : lo_tag;
    assign res_hi_tag = swap ? lo_tag : hi_tag;

endmodule

// File: rtl/bitonic_stream_sorter.sv
// Pipelined bitonic sorter, one SIZE-key vector per cycle; S = DEPTH*(DEPTH+1)/2 register stages.
// Whole pipe freezes while out_valid && !out_ready; in_ready = adv && rst_n, bubbles are kept.
module bitonic_stream_sorter
    import sort_pkg::*;
#(
    parameter int KEY_BITS = 8,
    parameter int TAG_BITS = 4,
    parameter int DEPTH    = 4,
    parameter int SIGNED   = 0,
    parameter int SIZE     = 1 << DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_dir,
    input  logic [SIZE-1:0][KEY_BITS-1:0]      in_keys,
    input  logic [SIZE-1:0][TAG_BITS-1:0]      in_tags,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_dir,
    output logic [SIZE-1:0][KEY_BITS-1:0]      out_keys,
    output logic [SIZE-1:0][TAG_BITS-1:0]      out_tags
);

    localparam int S = sort_stages(DEPTH);

    typedef logic [SIZE-1:0][KEY_BITS-1:0] keyvec_t;
    typedef logic [SIZE-1:0][TAG_BITS-1:0] tagvec_t;

    logic [S-1:0] stg_vld;
    logic [S-1:0] stg_dir;
    keyvec_t      stg_keys [S];
    tagvec_t      stg_tags [S];

    logic [S-1:0] src_vld;
    logic [S-1:0] src_dir;
    keyvec_t      src_keys [S];
    tagvec_t      src_tags [S];
    keyvec_t      nxt_keys [S];
    tagvec_t      nxt_tags [S];

    logic adv;

    assign out_valid = stg_vld[S-1];
    assign out_dir   = stg_dir[S-1];
    assign out_keys  = stg_keys[S-1];
    assign out_tags  = stg_tags[S-1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && rst_n;

    generate
        for (genvar s = 0; s < S; s++) begin : g_stage
            localparam int K = stage_k(s);
            localparam int J = stage_j(s);

            if (s == 0) begin : g_head
                assign src_vld[s]  = in_valid;
                assign src_dir[s]  = in_dir;
                assign src_keys[s] = in_keys;
                assign src_tags[s] = in_tags;
            end else begin : g_link
                assign src_vld[s]  = stg_vld[s-1];
                assign src_dir[s]  = stg_dir[s-1];
                assign src_keys[s] = stg_keys[s-1];
                assign src_tags[s] = stg_tags[s-1];
            end

            // Element i with bit j clear owns the pair (i, i ^ 2**j); bit k picks its direction.
            for (genvar i = 0; i < SIZE; i++) begin : g_elem
                if (((i >> J) & 1) == 0) begin : g_cas
                    sort_cas #(
                        .KEY_BITS (KEY_BITS),
                        .TAG_BITS (TAG_BITS),
                        .SIGNED   (SIGNED),
                        .ASCEND   (((i >> K) & 1) == 0)
                    ) u_cas (
                        .dir        (src_dir[s]),
                        .lo_key     (src_keys[s][i]),
                        .hi_key     (src_keys[s][i ^ (1 << J)]),
                        .lo_tag     (src_tags[s][i]),
                        .hi_tag     (src_tags[s][i ^ (1 << J)]),
                        .res_lo_key (nxt_keys[s][i]),
                        .res_hi_key (nxt_keys[s][i ^ (1 << J)]),
                        .res_lo_tag (nxt_tags[s][i]),
                        .res_hi_tag (nxt_tags[s][i ^ (1 << J)])
                    );
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_vld <= '0;
            stg_dir <= '0;
            for (int s = 0; s < S; s++) begin
                stg_keys[s] <= '0;
                stg_tags[s] <= '0;
            end
        end else if (adv) begin
            stg_vld <= src_vld;
            stg_dir <= src_dir;
            for (int s = 0; s < S; s++) begin
                stg_keys[s] <= nxt_keys[s];
                stg_tags[s] <= nxt_tags[s];
            end
        end
    end

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Bench for bitonic_stream_sorter: DEPTH=3 unsigned and DEPTH=4 signed instances,
// directed vectors plus randomized streams scored against a sort-based reference.
module tb_bitonic_stream_sorter;

    localparam int A_N = 8;
    localparam int A_S = 6;
    localparam int B_N = 16;
    localparam int B_S = 10;

    typedef struct packed {
        logic              lat;
        logic              dir;
        logic [15:0][7:0]  keys;
        logic [15:0][3:0]  tags;
        int                acc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   a_mode = 0;
    int   b_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                  a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready, a_out_dir;
    logic [A_N-1:0][7:0]   a_in_keys, a_out_keys;
    logic [A_N-1:0][3:0]   a_in_tags, a_out_tags;
    logic                  b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_out_dir;
    logic [B_N-1:0][7:0]   b_in_keys, b_out_keys;
    logic [B_N-1:0][3:0]   b_in_tags, b_out_tags;

    vec_t         qa[$];
    vec_t         qb[$];
    bit           held[2];
    logic [255:0] saved[2];

    int bk [8] = '{7, 3, 5, 1, 6, 0, 2, 4};
    int asc_tags [8] = '{5, 3, 6, 1, 7, 2, 4, 0};
    int dsc_tags [8] = '{0, 4, 2, 7, 1, 6, 3, 5};

    bitonic_stream_sorter #(.KEY_BITS(8), .TAG_BITS(4), .DEPTH(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_dir(a_in_dir),
        .in_keys(a_in_keys), .in_tags(a_in_tags),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_dir(a_out_dir),
        .out_keys(a_out_keys), .out_tags(a_out_tags)
    );

    bitonic_stream_sorter #(.KEY_BITS(8), .TAG_BITS(4), .DEPTH(4), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dir(b_in_dir),
        .in_keys(b_in_keys), .in_tags(b_in_tags),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_dir(b_out_dir),
        .out_keys(b_out_keys), .out_tags(b_out_tags)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain numeric sort of the first n keys, reversed for descending.
    function automatic logic [15:0][7:0] model_sort(input logic [15:0][7:0] k, input int n,
                                                    input bit sgn, input bit dir);
        int v [16];
        int tmp;
        logic [15:0][7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (sgn) v[i] = int'($signed(k[i]));
            else     v[i] = int'(k[i]);
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (v[j] > v[j+1]) begin
                    tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
                end
        for (int i = 0; i < n; i++) r[i] = 8'(dir ? v[n-1-i] : v[i]);
        return r;
    endfunction

    // Canonical form of the key/tag multiset, for permutation checks.
    function automatic logic [15:0][11:0] pairs(input logic [15:0][7:0] k,
                                                input logic [15:0][3:0] t, input int n);
        int c [16];
        int tmp;
        logic [15:0][11:0] r;
        r = '0;
        for (int i = 0; i < n; i++) c[i] = int'({k[i], t[i]});
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (c[j] > c[j+1]) begin
                    tmp = c[j]; c[j] = c[j+1]; c[j+1] = tmp;
                end
        for (int i = 0; i < n; i++) r[i] = 12'(c[i]);
        return r;
    endfunction

    task automatic mon(input int inst, input int n, input int s, input bit sgn,
                       input logic in_v, input logic in_r, input logic in_d,
                       input logic [15:0][7:0] ik, input logic [15:0][3:0] it,
                       input logic o_v, input logic o_r, input logic o_d,
                       input logic [15:0][7:0] ok, input logic [15:0][3:0] ot, input bit lat_mode);
        vec_t         e;
        logic [255:0] snap;
        string        pfx;
        bit           empty;
        pfx = (inst == 0) ? "a" : "b";
        if (!rst_n) begin
            held[inst] = 1'b0;
            return;
        end
        snap = 256'({o_v, o_d, ok, ot});
        if (held[inst]) chk({pfx, "_hold_stable"}, snap, saved[inst]);
        held[inst]  = o_v && !o_r;
        saved[inst] = snap;
        if (o_v && !o_r) chk({pfx, "_stall_in_ready"}, 256'(in_r), 256'(0));
        if (o_v && o_r) begin
            empty = (inst == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                chk({pfx, "_spurious_out"}, 256'(o_v), 256'(0));
            end else begin
                e = (inst == 0) ? qa.pop_front() : qb.pop_front();
                chk({pfx, "_dir"}, 256'(o_d), 256'(e.dir));
                chk({pfx, "_keys"}, 256'(ok), 256'(model_sort(e.keys, n, sgn, e.dir)));
                chk({pfx, "_pairs"}, 256'(pairs(ok, ot, n)), 256'(pairs(e.keys, e.tags, n)));
                if (e.lat) chk({pfx, "_latency"}, 256'(cyc - e.acc), 256'(s));
            end
        end
        if (in_v && in_r) begin
            e.lat  = lat_mode;
            e.dir  = in_d;
            e.keys = ik;
            e.tags = it;
            e.acc  = cyc;
            if (inst == 0) qa.push_back(e);
            else           qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        mon(0, A_N, A_S, 1'b0, a_in_valid, a_in_ready, a_in_dir, {64'd0, a_in_keys},
            {32'd0, a_in_tags}, a_out_valid, a_out_ready, a_out_dir, {64'd0, a_out_keys},
            {32'd0, a_out_tags}, a_mode == 0);
        mon(1, B_N, B_S, 1'b1, b_in_valid, b_in_ready, b_in_dir, b_in_keys, b_in_tags,
            b_out_valid, b_out_ready, b_out_dir, b_out_keys, b_out_tags, b_mode == 0);
    end

    initial begin
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_out_ready = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic send_a(input bit d, input logic [A_N-1:0][7:0] k, input logic [A_N-1:0][3:0] t);
        int w;
        a_in_valid = 1'b1; a_in_dir = d; a_in_keys = k; a_in_tags = t;
        w = 0;
        do begin @(negedge clk); w++; end while (!a_in_ready && w < 500);
        if (!a_in_ready) chk("a_send_timeout", 256'(a_in_ready), 256'(1));
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input bit d, input logic [B_N-1:0][7:0] k, input logic [B_N-1:0][3:0] t);
        int w;
        b_in_valid = 1'b1; b_in_dir = d; b_in_keys = k; b_in_tags = t;
        w = 0;
        do begin @(negedge clk); w++; end while (!b_in_ready && w < 500);
        if (!b_in_ready) chk("b_send_timeout", 256'(b_in_ready), 256'(1));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_vld(input int inst, output int w);
        w = 0;
        while (!((inst == 0) ? a_out_valid : b_out_valid) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
    endtask

    task automatic drain(input int inst);
        int w;
        w = 0;
        while (((inst == 0) ? qa.size() : qb.size()) != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk((inst == 0) ? "a_drain" : "b_drain", 256'((inst == 0) ? qa.size() : qb.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [A_N-1:0][7:0] ka, ea;
        logic [A_N-1:0][3:0] ta, et;
        logic [B_N-1:0][7:0] kb;
        logic [B_N-1:0][3:0] tb;
        logic [7:0]          mask;
        int                  w;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_dir = 1'b0; a_in_keys = '0; a_in_tags = '0;
        b_in_valid = 1'b0; b_in_dir = 1'b0; b_in_keys = '0; b_in_tags = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 256'(a_out_valid), 256'(0));
        chk("rst_a_outs", 256'({a_out_dir, a_out_keys, a_out_tags}), 256'(0));
        chk("rst_b_valid", 256'(b_out_valid), 256'(0));
        chk("rst_a_in_ready", 256'(a_in_ready), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("a_in_ready_idle", 256'(a_in_ready), 256'(1));

        // Directed ascending / descending on the 8-key instance.
        for (int i = 0; i < A_N; i++) begin ka[i] = 8'(bk[i]); ta[i] = 4'(i); end
        send_a(1'b0, ka, ta);
        wait_vld(0, w);
        chk("basic_latency", 256'(w), 256'(A_S - 1));
        for (int i = 0; i < A_N; i++) begin ea[i] = 8'(i); et[i] = 4'(asc_tags[i]); end
        chk("basic_keys", 256'(a_out_keys), 256'(ea));
        chk("basic_tags", 256'(a_out_tags), 256'(et));

        send_a(1'b1, ka, ta);
        wait_vld(0, w);
        for (int i = 0; i < A_N; i++) begin ea[i] = 8'(7 - i); et[i] = 4'(dsc_tags[i]); end
        chk("desc_keys", 256'(a_out_keys), 256'(ea));
        chk("desc_tags", 256'(a_out_tags), 256'(et));
        chk("desc_dir", 256'(a_out_dir), 256'(1));

        // All-equal keys: nothing swaps, tags must stay a permutation.
        for (int i = 0; i < A_N; i++) begin ka[i] = 8'hAA; ta[i] = 4'(i + 3); end
        send_a(1'($urandom_range(0, 1)), ka, ta);
        wait_vld(0, w);
        mask = '0;
        for (int i = 0; i < A_N; i++) mask[a_out_tags[i] - 4'd3] = 1'b1;
        chk("dup_keys", 256'(a_out_keys), 256'({A_N{8'hAA}}));
        chk("dup_tag_perm", 256'(mask), 256'(8'hFF));

        // Signed extremes on the 16-key instance.
        for (int i = 0; i < B_N; i++) begin kb[i] = 8'(i); tb[i] = 4'(i); end
        kb[0] = 8'hFF; kb[1] = 8'h7F; kb[2] = 8'h80; kb[3] = 8'h00;
        send_b(1'b0, kb, tb);
        wait_vld(1, w);
        chk("signed_latency", 256'(w), 256'(B_S - 1));
        chk("signed_min", 256'(b_out_keys[0]), 256'(8'h80));
        chk("signed_minus1", 256'(b_out_keys[1]), 256'(8'hFF));
        chk("signed_max", 256'(b_out_keys[15]), 256'(8'h7F));
        drain(0);
        drain(1);

        // Random backpressure stream with random idle gaps.
        a_mode = 1;
        for (int v = 0; v < 40; v++) begin
            for (int i = 0; i < A_N; i++) begin ka[i] = 8'($urandom); ta[i] = 4'($urandom); end
            send_a(1'($urandom_range(0, 1)), ka, ta);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain(0);
        a_mode = 0;

        // Fill the pipe against a stalled sink, then reset for one cycle.
        a_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        for (int v = 0; v < A_S; v++) begin
            for (int i = 0; i < A_N; i++) begin ka[i] = 8'($urandom); ta[i] = 4'($urandom); end
            send_a(1'($urandom_range(0, 1)), ka, ta);
        end
        chk("full_out_valid", 256'(a_out_valid), 256'(1));
        chk("full_in_ready", 256'(a_in_ready), 256'(0));
        rst_n = 1'b0;
        a_mode = 0;
        #1;
        chk("rst_b_in_ready", 256'(b_in_ready), 256'(0));
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", 256'(a_out_valid), 256'(0));
        chk("midrst_outs", 256'({a_out_dir, a_out_keys, a_out_tags}), 256'(0));
        repeat (12) begin @(posedge clk); #1; end
        for (int i = 0; i < A_N; i++) begin ka[i] = 8'(bk[i]); ta[i] = 4'(i); end
        send_a(1'b0, ka, ta);
        wait_vld(0, w);
        chk("midrst_latency", 256'(w), 256'(A_S - 1));
        for (int i = 0; i < A_N; i++) ea[i] = 8'(i);
        chk("midrst_keys", 256'(a_out_keys), 256'(ea));
        drain(0);

        // Full-rate random streams on both instances.
        for (int v = 0; v < 200; v++) begin
            for (int i = 0; i < A_N; i++) begin ka[i] = 8'($urandom); ta[i] = 4'($urandom); end
            send_a(1'($urandom_range(0, 1)), ka, ta);
        end
        drain(0);
        for (int v = 0; v < 1000; v++) begin
            for (int i = 0; i < B_N; i++) begin kb[i] = 8'($urandom); tb[i] = 4'($urandom); end
            send_b(1'($urandom_range(0, 1)), kb, tb);
        end
        drain(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
